// File: rtl/img_ram_access_sequencer_pkg.sv
// Shared types and constants for the ImgRam access sequencer.
package img_ram_access_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWrite   = 3'd1,
    StWaitRel = 3'd2,
    StProc    = 3'd3,
    StDone    = 3'd4
  } state_e;

  // Sticky error bit positions in err_flags
  localparam int unsigned ErrAddrRange    = 0;
  localparam int unsigned ErrStartRefused = 1;
  localparam int unsigned ErrTimeout      = 2;
  localparam int unsigned ErrStartDropped = 3;

  localparam int unsigned ImgPixelsDefault = 19200;
  localparam int unsigned TimeoutDefault   = 32'd1 << 22;

  // Width of a counter that must hold 0..n; never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/img_ram_access_sequencer_if.sv
// HPS pixel-write handshake: 4-phase req/ack with address and data.
interface img_ram_access_sequencer_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 8
);
  logic              hps_req;
  logic [ADDR_W-1:0] hps_addr;
  logic [DATA_W-1:0] hps_data;
  logic              hps_ack;

  modport master (output hps_req, output hps_addr, output hps_data, input hps_ack);
  modport slave  (input hps_req, input hps_addr, input hps_data, output hps_ack);
endinterface

// File: rtl/img_ram_access_sequencer_sync_edge_detect.sv
// Three-flop synchroniser with rise/fall pulses on the synchronised level.
module img_ram_access_sequencer_sync_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;

  // Shift the asynchronous input through the synchroniser chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/img_ram_access_sequencer.sv
// Serialises HPS pixel writes into ImgRam against image-processing jobs, so the RAM is
// never written while the processor is enabled.
module img_ram_access_sequencer
  import img_ram_access_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W         = 15,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned IMG_PIXELS     = ImgPixelsDefault,
  parameter bit          REQUIRE_FULL   = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutDefault
) (
  input  logic                       clk,
  input  logic                       reset_n,
  img_ram_access_sequencer_if.slave  hps,
  input  logic                       start_in,
  input  logic                       proc_done_in,
  input  logic                       clear_in,
  output logic                       proc_enable,
  output logic [ADDR_W-1:0]          ram_wraddr,
  output logic [DATA_W-1:0]          ram_wdata,
  output logic                       ram_wren,
  output logic                       busy,
  output logic [ADDR_W:0]            write_count,
  output logic                       img_complete,
  output logic [3:0]                 err_flags
);
  localparam int unsigned       TW          = cnt_width(TIMEOUT_CYCLES);
  localparam logic [ADDR_W:0]   PixLimit    = (ADDR_W + 1)'(IMG_PIXELS);
  localparam logic [TW-1:0]     TimeoutLast = TW'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ack_q, ack_d;
  logic              req_pend_q, req_pend_d;
  logic              start_pend_q, start_pend_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [3:0]        err_q, err_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              req_rise, req_fall, addr_ok, start_take;

  img_ram_access_sequencer_sync_edge_detect u_req_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (hps.hps_req),
    .rise    (req_rise),
    .fall    (req_fall)
  );

  assign addr_ok = ({1'b0, addr_q} < PixLimit);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      data_q       <= '0;
      ack_q        <= 1'b0;
      req_pend_q   <= 1'b0;
      start_pend_q <= 1'b0;
      count_q      <= '0;
      err_q        <= '0;
      tcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      ack_q        <= ack_d;
      req_pend_q   <= req_pend_d;
      start_pend_q <= start_pend_d;
      count_q      <= count_d;
      err_q        <= err_d;
      tcnt_q       <= tcnt_d;
    end
  end

  // Next-state, arbitration and write-port control
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    ack_d        = ack_q;
    req_pend_d   = req_pend_q;
    start_pend_d = start_pend_q;
    tcnt_d       = tcnt_q;
    count_d      = clear_in ? '0 : count_q;
    err_d        = clear_in ? '0 : err_q;
    ram_wren     = 1'b0;
    start_take   = 1'b0;

    // A request seen while busy is remembered and serviced on return to idle
    if (req_rise && (state_q != StIdle)) req_pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (req_rise || req_pend_q) begin
          // Writes win over a pending start in the same cycle
          addr_d     = hps.hps_addr;
          data_d     = hps.hps_data;
          req_pend_d = 1'b0;
          state_d    = StWrite;
        end else if (start_pend_q) begin
          start_take   = 1'b1;
          start_pend_d = 1'b0;
          if (REQUIRE_FULL && !img_complete) begin
            err_d[ErrStartRefused] = 1'b1;
          end else begin
            tcnt_d  = '0;
            state_d = StProc;
          end
        end
      end
      StWrite: begin
        if (addr_ok) begin
          ram_wren = 1'b1;
          if (count_d < PixLimit) count_d = count_d + 1'b1;
        end else begin
          err_d[ErrAddrRange] = 1'b1;
        end
        ack_d   = 1'b1;
        state_d = StWaitRel;
      end
      StWaitRel: begin
        if (req_fall) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end
      StProc: begin
        if (proc_done_in) begin
          state_d = StDone;
        end else if ((TIMEOUT_CYCLES != 0) && (tcnt_q == TimeoutLast)) begin
          err_d[ErrTimeout] = 1'b1;
          state_d           = StIdle;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A second start while one is still queued is dropped and flagged
    if (start_in) begin
      if (start_pend_q && !start_take) err_d[ErrStartDropped] = 1'b1;
      start_pend_d = 1'b1;
    end
  end

  assign hps.hps_ack   = ack_q;
  assign proc_enable   = (state_q == StProc);
  assign busy          = (state_q != StIdle);
  assign ram_wraddr    = addr_q;
  assign ram_wdata     = data_q;
  assign write_count   = count_q;
  assign img_complete  = (count_q == PixLimit);
  assign err_flags     = err_q;
endmodule
